siso_shift_ctrl: RTL and testbench

SISO_SHIFT_CTRL -- requirements
Module: siso_shift_ctrl

---
 rtl/siso_shift_ctrl.sv | 117 +++++++++++
 tb/tb_siso_shift_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/siso_shift_ctrl.sv
// Serializes a parallel word LSB-first into an external SISO shift chain and
// reassembles the frame returning on the chain output for a loopback compare.
module siso_shift_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             si,
   output logic             shift_en,
   input  logic             chain_so,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             match,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + DEPTH - 1);
   localparam logic [CW-1:0] CNT_TX   = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_RX   = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [WIDTH-1:0] tx_reg;
   logic [WIDTH-1:0] ref_reg;
   logic [WIDTH-1:0] rx_reg;
   logic [WIDTH-1:0] rx_nxt;

   assign cnt_nxt = cnt + 1'b1;
   assign rx_nxt  = {chain_so, rx_reg[WIDTH-1:1]};
   assign rx_data = rx_reg;

   // si/shift_en are registered one cycle ahead: the value loaded at each edge
   // is the frame bit belonging to the cnt value that edge moves into.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state      <= IDLE;
         cnt        <= '0;
         tx_reg     <= '0;
         ref_reg    <= '0;
         rx_reg     <= '0;
         si         <= 1'b0;
         shift_en   <= 1'b0;
         rx_valid   <= 1'b0;
         match      <= 1'b0;
         load_ready <= 1'b1;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_valid) begin
                  state      <= SHIFT;
                  cnt        <= '0;
                  tx_reg     <= load_data;
                  ref_reg    <= load_data;
                  rx_reg     <= '0;
                  si         <= load_data[0];
                  shift_en   <= 1'b1;
                  load_ready <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            SHIFT: begin
               if (cnt < CNT_TX) begin
                  tx_reg <= {1'b0, tx_reg[WIDTH-1:1]};
               end
               // The first DEPTH cycles of chain_so still hold stale chain contents.
               if (cnt >= CNT_RX) begin
                  rx_reg <= rx_nxt;
               end
               if (cnt == CNT_LAST) begin
                  state    <= DONE;
                  si       <= 1'b0;
                  shift_en <= 1'b0;
                  rx_valid <= 1'b1;
                  match    <= (rx_nxt == ref_reg);
               end else begin
                  cnt      <= cnt_nxt;
                  si       <= (cnt_nxt < CNT_TX) ? tx_reg[1] : 1'b0;
                  shift_en <= (cnt_nxt < CNT_TX);
               end
            end
            DONE: begin
               if (rx_ready) begin
                  state      <= IDLE;
                  rx_valid   <= 1'b0;
                  match      <= 1'b0;
                  load_ready <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               rx_valid   <= 1'b0;
               match      <= 1'b0;
               si         <= 1'b0;
               shift_en   <= 1'b0;
               load_ready <= 1'b1;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Bench for siso_shift_ctrl: frame-level model checked every cycle plus
// directed scenarios with hand-computed literals (8/4 loopback and 4/1 chains).
module tb_siso_shift_ctrl;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int W2 = 4;
   localparam int D2 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          clr;
   logic          load_valid;
   logic [W-1:0]  load_data;
   logic          load_ready, si, shift_en, chain_so, rx_valid, rx_ready, match, busy;
   logic [W-1:0]  rx_data;
   logic [D-1:0]  chain = '0;
   logic          loopback;

   logic          lv2, rr2, lr2, si2, se2, cso2, rv2, m2, b2;
   logic [W2-1:0] ld2, rd2;
   logic          chain2 = 1'b0;

   int total = 0;
   int bad   = 0;

   siso_shift_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .clr(clr), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .si(si), .shift_en(shift_en), .chain_so(chain_so),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .match(match), .busy(busy)
   );

   siso_shift_ctrl #(.WIDTH(W2), .DEPTH(D2)) dut2 (
      .clk(clk), .clr(clr), .load_valid(lv2), .load_data(ld2),
      .load_ready(lr2), .si(si2), .shift_en(se2), .chain_so(cso2),
      .rx_valid(rv2), .rx_ready(rr2), .rx_data(rd2),
      .match(m2), .busy(b2)
   );

   // Free-running external chains; chain_so can be forced low to break loopback.
   always @(posedge clk) chain <= {chain[D-2:0], si};
   assign chain_so = loopback ? chain[D-1] : 1'b0;
   always @(posedge clk) chain2 <= si2;
   assign cso2 = chain2;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic lv, input logic [W-1:0] ld, input logic rr);
      load_valid = lv;
      load_data  = ld;
      rx_ready   = rr;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Frame-level model: a frame is a word plus the number of cycles since it
   // was accepted; it is serialized for W cycles and reported after W+D cycles.
   bit           m_ok = 1'b0;
   bit           m_active = 1'b0;
   bit           m_done = 1'b0;
   int           m_k = 0;
   logic [W-1:0] m_word = '0;
   logic [W-1:0] m_rx = '0;

   always @(posedge clk) begin
      if (!clr) begin
         m_ok     <= 1'b1;
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_k      <= 0;
      end else if (!m_active) begin
         if (load_valid) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_word   <= load_data;
            m_rx     <= loopback ? load_data : '0;
         end
      end else if (!m_done) begin
         m_k <= m_k + 1;
         if (m_k + 1 == W + D) m_done <= 1'b1;
      end else if (rx_ready) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
      end
   end

   logic [W-1:0] dq[$];
   always @(posedge clk) begin
      if (clr && rx_valid && rx_ready) dq.push_back(rx_data);
   end

   always @(negedge clk) begin
      if (m_ok) begin
         logic exp_sh;
         exp_sh = m_active && !m_done && (m_k < W);
         checkOutput("load_ready", 32'(load_ready), 32'(!m_active));
         checkOutput("busy", 32'(busy), 32'(m_active));
         checkOutput("shift_en", 32'(shift_en), 32'(exp_sh));
         checkOutput("si", 32'(si), exp_sh ? 32'(m_word[m_k]) : 32'd0);
         checkOutput("rx_valid", 32'(rx_valid), 32'(m_done));
         checkOutput("match", 32'(match), 32'(m_done && (m_rx == m_word)));
         if (m_done) checkOutput("rx_data", 32'(rx_data), 32'(m_rx));
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [W-1:0]  seqv;
      logic [W2-1:0] seq2;
      int sh, early, cyc, n2, guard;

      clr = 1'b0;
      loopback = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      lv2 = 1'b0; ld2 = '0; rr2 = 1'b0;
      step(2);
      checkOutput("rst_load_ready", 32'(load_ready), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_si", 32'(si), 32'd0);
      checkOutput("rst_shift_en", 32'(shift_en), 32'd0);
      checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
      checkOutput("rst_match", 32'(match), 32'd0);
      checkOutput("rst2_load_ready", 32'(lr2), 32'd1);
      checkOutput("rst2_rx_valid", 32'(rv2), 32'd0);
      clr = 1'b1;
      step(1);

      // Loopback of A5: serial order, latency and compare result.
      applyStimulus(1'b1, 8'hA5, 1'b0);
      step(1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      seqv = '0; sh = 0; early = 0;
      for (int c = 0; c < W + D; c++) begin
         if (shift_en) begin
            if (sh < W) seqv[sh] = si;
            sh++;
         end
         if (rx_valid) early++;
         step(1);
      end
      checkOutput("a5_si_seq", 32'(seqv), 32'hA5);
      checkOutput("a5_shift_cycles", 32'(sh), 32'd8);
      checkOutput("a5_early_valid", 32'(early), 32'd0);
      checkOutput("a5_rx_valid", 32'(rx_valid), 32'd1);
      checkOutput("a5_rx_data", 32'(rx_data), 32'hA5);
      checkOutput("a5_match", 32'(match), 32'd1);
      step(2);
      applyStimulus(1'b0, 8'h00, 1'b1);
      step(1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("a5_release", 32'(load_ready), 32'd1);

      // Broken chain: zeros received, frame held until consumed.
      loopback = 1'b0;
      applyStimulus(1'b1, 8'hA5, 1'b0);
      step(1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      step(12);
      checkOutput("zero_rx_data", 32'(rx_data), 32'h00);
      checkOutput("zero_match", 32'(match), 32'd0);
      step(3);
      checkOutput("zero_hold", 32'(rx_valid), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      step(1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("zero_idle", 32'(busy), 32'd0);
      loopback = 1'b1;

      // Back-to-back frames with load_valid and rx_ready held high.
      dq.delete();
      applyStimulus(1'b1, 8'h01, 1'b1);
      step(1);
      applyStimulus(1'b1, 8'hFF, 1'b1);
      step(14);
      applyStimulus(1'b0, 8'h00, 1'b1);
      step(14);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("b2b_count", 32'(dq.size()), 32'd2);
      if (dq.size() == 2) begin
         checkOutput("b2b_first", 32'(dq[0]), 32'h01);
         checkOutput("b2b_second", 32'(dq[1]), 32'hFF);
      end

      // Reset in the middle of a frame at cnt=5.
      applyStimulus(1'b1, 8'h5A, 1'b0);
      step(1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      step(5);
      clr = 1'b0;
      step(1);
      clr = 1'b1;
      checkOutput("mid_load_ready", 32'(load_ready), 32'd1);
      checkOutput("mid_busy", 32'(busy), 32'd0);
      checkOutput("mid_si", 32'(si), 32'd0);
      checkOutput("mid_shift_en", 32'(shift_en), 32'd0);
      checkOutput("mid_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("mid_rx_data", 32'(rx_data), 32'd0);
      checkOutput("mid_match", 32'(match), 32'd0);
      step(16);
      applyStimulus(1'b1, 8'h3C, 1'b0);
      step(1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      step(12);
      checkOutput("c3_rx_valid", 32'(rx_valid), 32'd1);
      checkOutput("c3_rx_data", 32'(rx_data), 32'h3C);
      checkOutput("c3_match", 32'(match), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      step(1);
      applyStimulus(1'b0, 8'h00, 1'b0);

      // Stray loads during SHIFT and DONE are ignored.
      applyStimulus(1'b1, 8'h96, 1'b0);
      step(1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      step(3);
      applyStimulus(1'b1, 8'h0F, 1'b0);
      step(1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      step(8);
      applyStimulus(1'b1, 8'hF0, 1'b0);
      step(1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("ign_rx_valid", 32'(rx_valid), 32'd1);
      checkOutput("ign_rx_data", 32'(rx_data), 32'h96);
      checkOutput("ign_match", 32'(match), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      step(1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      step(4);
      checkOutput("ign_idle", 32'(busy), 32'd0);

      // Minimal chain: WIDTH=4, DEPTH=1.
      lv2 = 1'b1; ld2 = 4'b1001;
      step(1);
      lv2 = 1'b0; ld2 = 4'b0000;
      cyc = 0; n2 = 0; seq2 = '0; guard = 0;
      while (!rv2 && guard < 20) begin
         if (b2) cyc++;
         if (se2) begin
            if (n2 < W2) seq2[n2] = si2;
            n2++;
         end
         guard++;
         step(1);
      end
      checkOutput("small_timeout", 32'(rv2), 32'd1);
      checkOutput("small_shift_len", 32'(cyc), 32'd5);
      checkOutput("small_si_seq", 32'(seq2), 32'h9);
      checkOutput("small_rx_data", 32'(rd2), 32'h9);
      checkOutput("small_match", 32'(m2), 32'd1);
      rr2 = 1'b1;
      step(1);
      rr2 = 1'b0;
      checkOutput("small_idle", 32'(b2), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
